// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: operand forwarding, single-cycle ALU, iterative MUL/DIVU/REMU, EX/MEM register
// Stall is raised combinationally on acceptance of a multicycle op and held until its result is ready.
module ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int MC_CYCLES  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  stage_ID_EX__EX_regwrite,
  input  logic                  stage_ID_EX__EX_memtoreg,
  input  logic                  stage_ID_EX__EX_memread,
  input  logic                  stage_ID_EX__EX_memwrite,
  input  logic                  stage_ID_EX__EX_alusrc,
  input  logic [3:0]            stage_ID_EX__EX_aluop,
  input  logic [DATA_WIDTH-1:0] stage_ID_EX__EX_rs1_data,
  input  logic [DATA_WIDTH-1:0] stage_ID_EX__EX_rs2_data,
  input  logic [DATA_WIDTH-1:0] stage_ID_EX__EX_imm,
  input  logic [4:0]            stage_ID_EX__EX_rd_id,
  input  logic [1:0]            FU__EX_fwd_a,
  input  logic [1:0]            FU__EX_fwd_b,
  input  logic [DATA_WIDTH-1:0] MEM__EX_fwd_data,
  input  logic [DATA_WIDTH-1:0] WB__EX_fwd_data,
  output logic                  EX__HDU_stall,
  output logic                  stage_EX_MEM__MEM_regwrite,
  output logic                  stage_EX_MEM__MEM_memtoreg,
  output logic                  stage_EX_MEM__MEM_memread,
  output logic                  stage_EX_MEM__MEM_memwrite,
  output logic [DATA_WIDTH-1:0] stage_EX_MEM__MEM_alures,
  output logic [DATA_WIDTH-1:0] stage_EX_MEM__MEM_store_data,
  output logic [4:0]            stage_EX_MEM__MEM_rd_id
);

  localparam int CW = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(MC_CYCLES - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  logic [CW-1:0]         r_cnt;
  logic [3:0]            r_mc_op;
  logic [DATA_WIDTH-1:0] r_a, r_b, r_acc;
  logic                  r_l_regwrite, r_l_memtoreg, r_l_memread, r_l_memwrite;
  logic [4:0]            r_l_rd_id;
  logic [DATA_WIDTH-1:0] r_l_store_data;

  logic [DATA_WIDTH-1:0] w_op_a, w_fwd_b, w_op_b, w_alu, w_mc_result, w_rem_diff;
  logic [DATA_WIDTH:0]   w_rem_shift;
  logic [4:0]            w_shamt;
  logic                  w_is_mc, w_accept, w_rem_ge, w_stall;

  function automatic logic [DATA_WIDTH-1:0] fwd_sel(input logic [1:0] sel,
                                                    input logic [DATA_WIDTH-1:0] rs,
                                                    input logic [DATA_WIDTH-1:0] mem,
                                                    input logic [DATA_WIDTH-1:0] wb);
    case (sel)
      2'b01:   fwd_sel = mem;
      2'b10:   fwd_sel = wb;
      default: fwd_sel = rs;
    endcase
  endfunction

  assign w_op_a  = fwd_sel(FU__EX_fwd_a, stage_ID_EX__EX_rs1_data, MEM__EX_fwd_data, WB__EX_fwd_data);
  assign w_fwd_b = fwd_sel(FU__EX_fwd_b, stage_ID_EX__EX_rs2_data, MEM__EX_fwd_data, WB__EX_fwd_data);
  assign w_op_b  = stage_ID_EX__EX_alusrc ? stage_ID_EX__EX_imm : w_fwd_b;
  assign w_shamt = w_op_b[4:0];

  always_comb begin
    w_alu = '0;
    case (stage_ID_EX__EX_aluop)
      OP_ADD:  w_alu = w_op_a + w_op_b;
      OP_SUB:  w_alu = w_op_a - w_op_b;
      OP_AND:  w_alu = w_op_a & w_op_b;
      OP_OR:   w_alu = w_op_a | w_op_b;
      OP_XOR:  w_alu = w_op_a ^ w_op_b;
      OP_SLL:  w_alu = w_op_a << w_shamt;
      OP_SRL:  w_alu = w_op_a >> w_shamt;
      OP_SRA:  w_alu = $unsigned($signed(w_op_a) >>> w_shamt);
      OP_SLT:  w_alu = {{(DATA_WIDTH-1){1'b0}}, $signed(w_op_a) < $signed(w_op_b)};
      OP_SLTU: w_alu = {{(DATA_WIDTH-1){1'b0}}, w_op_a < w_op_b};
      default: w_alu = '0;
    endcase
  end

  assign w_is_mc  = (stage_ID_EX__EX_aluop == OP_MUL) || (stage_ID_EX__EX_aluop == OP_DIVU) ||
                    (stage_ID_EX__EX_aluop == OP_REMU);
  assign w_accept = (r_state == S_IDLE) && en && w_is_mc;
  assign w_stall  = w_accept || (r_state == S_BUSY);
  assign EX__HDU_stall = w_stall;

  // Restoring divide: r_a shifts dividend out / quotient in, r_acc is the partial remainder.
  // A zero divisor always "fits", yielding an all-ones quotient and the dividend as remainder.
  assign w_rem_shift = {r_acc, r_a[DATA_WIDTH-1]};
  assign w_rem_ge    = w_rem_shift >= {1'b0, r_b};
  assign w_rem_diff  = w_rem_shift[DATA_WIDTH-1:0] - r_b;

  always_comb begin
    case (r_mc_op)
      OP_DIVU: w_mc_result = r_a;
      default: w_mc_result = r_acc;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_BUSY;
      S_BUSY:  if (r_cnt == LAST_ITER) w_state_nxt = S_DONE;
      S_DONE:  if (en) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt          <= '0;
      r_mc_op        <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_acc          <= '0;
      r_l_regwrite   <= 1'b0;
      r_l_memtoreg   <= 1'b0;
      r_l_memread    <= 1'b0;
      r_l_memwrite   <= 1'b0;
      r_l_rd_id      <= '0;
      r_l_store_data <= '0;
    end else if (w_accept) begin
      r_cnt          <= '0;
      r_mc_op        <= stage_ID_EX__EX_aluop;
      r_a            <= w_op_a;
      r_b            <= w_op_b;
      r_acc          <= '0;
      r_l_regwrite   <= stage_ID_EX__EX_regwrite;
      r_l_memtoreg   <= stage_ID_EX__EX_memtoreg;
      r_l_memread    <= stage_ID_EX__EX_memread;
      r_l_memwrite   <= stage_ID_EX__EX_memwrite;
      r_l_rd_id      <= stage_ID_EX__EX_rd_id;
      r_l_store_data <= w_fwd_b;
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_mc_op == OP_MUL) begin
        if (r_b[0]) r_acc <= r_acc + r_a;
        r_a <= r_a << 1;
        r_b <= r_b >> 1;
      end else begin
        r_acc <= w_rem_ge ? w_rem_diff : w_rem_shift[DATA_WIDTH-1:0];
        r_a   <= {r_a[DATA_WIDTH-2:0], w_rem_ge};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_EX_MEM__MEM_regwrite   <= 1'b0;
      stage_EX_MEM__MEM_memtoreg   <= 1'b0;
      stage_EX_MEM__MEM_memread    <= 1'b0;
      stage_EX_MEM__MEM_memwrite   <= 1'b0;
      stage_EX_MEM__MEM_alures     <= '0;
      stage_EX_MEM__MEM_store_data <= '0;
      stage_EX_MEM__MEM_rd_id      <= '0;
    end else if (en) begin
      if (w_stall) begin
        stage_EX_MEM__MEM_regwrite   <= 1'b0;
        stage_EX_MEM__MEM_memtoreg   <= 1'b0;
        stage_EX_MEM__MEM_memread    <= 1'b0;
        stage_EX_MEM__MEM_memwrite   <= 1'b0;
        stage_EX_MEM__MEM_alures     <= '0;
        stage_EX_MEM__MEM_store_data <= '0;
        stage_EX_MEM__MEM_rd_id      <= '0;
      end else if (r_state == S_DONE) begin
        stage_EX_MEM__MEM_regwrite   <= r_l_regwrite;
        stage_EX_MEM__MEM_memtoreg   <= r_l_memtoreg;
        stage_EX_MEM__MEM_memread    <= r_l_memread;
        stage_EX_MEM__MEM_memwrite   <= r_l_memwrite;
        stage_EX_MEM__MEM_alures     <= w_mc_result;
        stage_EX_MEM__MEM_store_data <= r_l_store_data;
        stage_EX_MEM__MEM_rd_id      <= r_l_rd_id;
      end else begin
        stage_EX_MEM__MEM_regwrite   <= stage_ID_EX__EX_regwrite;
        stage_EX_MEM__MEM_memtoreg   <= stage_ID_EX__EX_memtoreg;
        stage_EX_MEM__MEM_memread    <= stage_ID_EX__EX_memread;
        stage_EX_MEM__MEM_memwrite   <= stage_ID_EX__EX_memwrite;
        stage_EX_MEM__MEM_alures     <= w_alu;
        stage_EX_MEM__MEM_store_data <= w_fwd_b;
        stage_EX_MEM__MEM_rd_id      <= stage_ID_EX__EX_rd_id;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage
// Table vectors, hand-written multicycle sequences and random ops against an arithmetic reference model.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst, en;
  logic        regwrite, memtoreg, memread, memwrite, alusrc;
  logic [3:0]  aluop;
  logic [31:0] rs1, rs2, imm, mem_fwd, wb_fwd;
  logic [4:0]  rd_id;
  logic [1:0]  fwd_a, fwd_b;
  logic        stall;
  logic        o_regwrite, o_memtoreg, o_memread, o_memwrite;
  logic [31:0] o_alures, o_store;
  logic [4:0]  o_rd;

  int n_checks = 0;
  int n_errors = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .en(en),
    .stage_ID_EX__EX_regwrite(regwrite), .stage_ID_EX__EX_memtoreg(memtoreg),
    .stage_ID_EX__EX_memread(memread), .stage_ID_EX__EX_memwrite(memwrite),
    .stage_ID_EX__EX_alusrc(alusrc), .stage_ID_EX__EX_aluop(aluop),
    .stage_ID_EX__EX_rs1_data(rs1), .stage_ID_EX__EX_rs2_data(rs2),
    .stage_ID_EX__EX_imm(imm), .stage_ID_EX__EX_rd_id(rd_id),
    .FU__EX_fwd_a(fwd_a), .FU__EX_fwd_b(fwd_b),
    .MEM__EX_fwd_data(mem_fwd), .WB__EX_fwd_data(wb_fwd),
    .EX__HDU_stall(stall),
    .stage_EX_MEM__MEM_regwrite(o_regwrite), .stage_EX_MEM__MEM_memtoreg(o_memtoreg),
    .stage_EX_MEM__MEM_memread(o_memread), .stage_EX_MEM__MEM_memwrite(o_memwrite),
    .stage_EX_MEM__MEM_alures(o_alures), .stage_EX_MEM__MEM_store_data(o_store),
    .stage_EX_MEM__MEM_rd_id(o_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, imm;
    logic        alusrc;
    logic [1:0]  fa, fb;
    logic [31:0] mem, wb;
    logic [31:0] exp_res, exp_st;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fsel(input logic [1:0] s, input logic [31:0] rs, m, w);
    if (s == 2'b01) return m;
    if (s == 2'b10) return w;
    return rs;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << b[4:0];
      4'd6:  return a >> b[4:0];
      4'd7:  return $unsigned($signed(a) >>> b[4:0]);
      4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return p[31:0];
      4'd11: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd12: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_nop();
    aluop = 4'd13; regwrite = 0; memtoreg = 0; memread = 0; memwrite = 0;
    alusrc = 0; fwd_a = 0; fwd_b = 0; rs1 = 0; rs2 = 0; imm = 0; rd_id = 0;
    mem_fwd = 0; wb_fwd = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Multicycle op with operands on rs1/rs2; optional perturbation at BUSY cycle and en=0 hold in DONE.
  task automatic run_mc(input string name, input logic [3:0] op, input logic [31:0] a, b,
                        input int perturb, input int hold);
    logic [31:0] exp;
    int stalls;
    bit done, bubble_bad;
    exp = ref_alu(op, a, b);
    aluop = op; rs1 = a; rs2 = b; alusrc = 0; fwd_a = 0; fwd_b = 0; imm = $urandom;
    mem_fwd = $urandom; wb_fwd = $urandom;
    regwrite = 1; memtoreg = 0; memread = 0; memwrite = 0; rd_id = 5'd9; en = 1;
    #1;
    check({name, "_accept_stall"}, 32'(stall), 32'd1);
    stalls = 1; done = 0; bubble_bad = 0;
    for (int k = 1; k <= 100 && !done; k++) begin
      tick();
      if (stall) begin
        stalls++;
        if (o_alures != 0 || o_regwrite || o_rd != 0 || o_store != 0) bubble_bad = 1;
      end else begin
        done = 1;
      end
      if (k == perturb) begin
        rs1 = $urandom; rs2 = $urandom; imm = $urandom; alusrc = 1;
        fwd_a = 2'b01; fwd_b = 2'b10; mem_fwd = $urandom; wb_fwd = $urandom;
        rd_id = 5'd17; regwrite = 0;
      end
    end
    check({name, "_done_seen"}, 32'(done), 32'd1);
    check({name, "_stall_cycles"}, 32'(stalls), 32'd33);
    check({name, "_bubbles"}, 32'(bubble_bad), 32'd0);
    if (hold > 0) begin
      en = 0;
      repeat (hold) tick();
      check({name, "_hold_alures"}, o_alures, 32'd0);
      check({name, "_hold_regwrite"}, 32'(o_regwrite), 32'd0);
      check({name, "_hold_stall"}, 32'(stall), 32'd0);
      en = 1;
    end
    tick();
    check({name, "_result"}, o_alures, exp);
    check({name, "_rd"}, 32'(o_rd), 32'd9);
    check({name, "_regwrite"}, 32'(o_regwrite), 32'd1);
    check({name, "_store"}, o_store, b);
    set_nop();
  endtask

  initial begin
    logic [31:0] a, b, st, exp;
    vecs[0]  = '{4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 32'd12, 32'd7};
    vecs[1]  = '{4'd1, 32'hDEAD, 32'd1, 32'd0, 1'b0, 2'b01, 2'b00, 32'h100, 32'h0, 32'hFF, 32'd1};
    vecs[2]  = '{4'd7, 32'h8000_0000, 32'h55, 32'hFFFF_FFFF, 1'b1, 2'b00, 2'b00, 32'h0, 32'h0,
                 32'hFFFF_FFFF, 32'h55};
    vecs[3]  = '{4'd2, 32'h00FF, 32'h1234, 32'd0, 1'b0, 2'b00, 2'b10, 32'h0, 32'h0F0F, 32'h000F, 32'h0F0F};
    vecs[4]  = '{4'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'd1, 32'd1};
    vecs[5]  = '{4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'd0, 32'd1};
    vecs[6]  = '{4'd5, 32'd1, 32'h21, 32'd0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'd2, 32'h21};
    vecs[7]  = '{4'd6, 32'h8000_0000, 32'd31, 32'd0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'd1, 32'd31};
    vecs[8]  = '{4'd4, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'd0, 1'b0, 2'b11, 2'b11, 32'h1, 32'h2,
                 32'h0F0F_0F0F, 32'hFFFF_FFFF};
    vecs[9]  = '{4'd14, 32'd3, 32'd4, 32'd0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'd0, 32'd4};
    vecs[10] = '{4'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'd1, 32'd2};
    vecs[11] = '{4'd3, 32'h0C, 32'h999, 32'd0, 1'b0, 2'b00, 2'b01, 32'h30, 32'h0, 32'h3C, 32'h30};

    rst = 1; en = 1; set_nop();
    tick(); tick();
    check("reset_alures", o_alures, 32'd0);
    check("reset_ctrl", {28'd0, o_regwrite, o_memtoreg, o_memread, o_memwrite}, 32'd0);
    check("reset_rd", 32'(o_rd), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    rst = 0;

    for (int i = 0; i < 12; i++) begin
      aluop = vecs[i].op; rs1 = vecs[i].a; rs2 = vecs[i].b; imm = vecs[i].imm;
      alusrc = vecs[i].alusrc; fwd_a = vecs[i].fa; fwd_b = vecs[i].fb;
      mem_fwd = vecs[i].mem; wb_fwd = vecs[i].wb;
      regwrite = i[0]; memtoreg = i[1]; memread = i[2]; memwrite = ~i[0]; rd_id = 5'(i + 1);
      #1;
      check($sformatf("vec%0d_stall", i), 32'(stall), 32'd0);
      tick();
      check($sformatf("vec%0d_alures", i), o_alures, vecs[i].exp_res);
      check($sformatf("vec%0d_store", i), o_store, vecs[i].exp_st);
      check($sformatf("vec%0d_ctrl", i), {27'd0, o_rd, o_regwrite, o_memtoreg, o_memread, o_memwrite},
            {27'd0, 5'(i + 1), i[0], i[1], i[2], ~i[0]});
    end

    en = 0; aluop = 4'd0; rs1 = 32'd1; rs2 = 32'd1; rd_id = 5'd30; regwrite = 1;
    tick();
    check("en0_hold_alures", o_alures, 32'h3C);
    check("en0_hold_rd", 32'(o_rd), 32'd12);
    en = 1; set_nop();

    run_mc("mul", 4'd10, 32'h0001_0003, 32'h0002_0005, 0, 0);
    check("mul_const", o_alures, 32'h000B_000F);
    run_mc("divu", 4'd11, 32'd100, 32'd7, 0, 0);
    check("divu_const", o_alures, 32'd14);
    run_mc("remu", 4'd12, 32'd100, 32'd7, 0, 0);
    check("remu_const", o_alures, 32'd2);
    run_mc("divu0", 4'd11, 32'd9, 32'd0, 0, 0);
    check("divu0_const", o_alures, 32'hFFFF_FFFF);
    run_mc("remu0", 4'd12, 32'd9, 32'd0, 0, 0);
    check("remu0_const", o_alures, 32'd9);
    run_mc("mul_perturb_hold", 4'd10, 32'h1234_5678, 32'h9ABC_DEF1, 10, 3);

    // Reset during BUSY abandons the op; the following ADD must go through in one cycle.
    aluop = 4'd10; rs1 = 32'd77; rs2 = 32'd88; regwrite = 1; rd_id = 5'd4; en = 1;
    repeat (16) tick();
    check("rst_pre_stall", 32'(stall), 32'd1);
    rst = 1; set_nop(); aluop = 4'd0; rs1 = 32'd3; rs2 = 32'd4; regwrite = 1; rd_id = 5'd6;
    #1;
    check("rst_mid_stall", 32'(stall), 32'd0);
    check("rst_mid_alures", o_alures, 32'd0);
    tick();
    check("rst_hold_regwrite", 32'(o_regwrite), 32'd0);
    rst = 0;
    tick();
    check("post_rst_add", o_alures, 32'd7);
    check("post_rst_rd", 32'(o_rd), 32'd6);
    check("post_rst_stall", 32'(stall), 32'd0);
    set_nop();

    for (int it = 0; it < 60; it++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (op >= 4'd10 && op <= 4'd12) begin
        a = $urandom;
        b = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom);
        run_mc($sformatf("rnd%0d_mc", it), op, a, b, 0, 0);
      end else begin
        aluop = op; rs1 = $urandom; rs2 = $urandom; imm = $urandom; alusrc = 1'($urandom);
        fwd_a = 2'($urandom); fwd_b = 2'($urandom); mem_fwd = $urandom; wb_fwd = $urandom;
        regwrite = 1'($urandom); memwrite = 1'($urandom); rd_id = 5'($urandom);
        a = fsel(fwd_a, rs1, mem_fwd, wb_fwd);
        st = fsel(fwd_b, rs2, mem_fwd, wb_fwd);
        b = alusrc ? imm : st;
        exp = ref_alu(op, a, b);
        tick();
        check($sformatf("rnd%0d_op%0d_alures", it, op), o_alures, exp);
        check($sformatf("rnd%0d_store", it), o_store, st);
        check($sformatf("rnd%0d_ctrl", it), {25'd0, o_rd, o_regwrite, o_memwrite},
              {25'd0, rd_id, regwrite, memwrite});
        set_nop();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
